stream_demux_1_2: RTL and testbench

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It takes one input beat stream and routes each beat to output channel A or B, according to a select bit carried with that beat. It is the splitting counterpart of the datapath 2:1 selector. It sits between a producer, such as the core's store/IO path, and two independent consumers, such as peripheral or memory ports. Each output has a one-entry register slice and a delivered-beat counter.

---
 rtl/stream_demux_1_2.sv | 77 +++++++
 tb/tb_stream_demux_1_2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_2.sv
// Registered 1-to-2 stream demultiplexer: each input beat is steered to channel A or B
// by its select bit, through a one-entry register slice per channel with a delivered-beat counter.
module stream_demux_1_2 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [CNT_WIDTH-1:0]  a_count,
  output logic [CNT_WIDTH-1:0]  b_count
);

  logic a_free;
  logic b_free;
  logic a_load;
  logic b_load;
  logic a_drain;
  logic b_drain;

  // A slice can take a beat when empty or when its current beat leaves this cycle,
  // so a stalled channel only back-pressures beats addressed to it.
  assign a_free   = !a_valid || a_ready;
  assign b_free   = !b_valid || b_ready;
  assign in_ready = in_sel ? b_free : a_free;

  assign a_load  = in_valid && !in_sel && a_free;
  assign b_load  = in_valid &&  in_sel && b_free;
  assign a_drain = a_valid && a_ready;
  assign b_drain = b_valid && b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_count <= '0;
    end else begin
      if (a_load) begin
        a_data  <= in_data;
        a_valid <= 1'b1;
      end else if (a_drain) begin
        a_valid <= 1'b0;
      end
      if (a_drain) begin
        a_count <= a_count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_count <= '0;
    end else begin
      if (b_load) begin
        b_data  <= in_data;
        b_valid <= 1'b1;
      end else if (b_drain) begin
        b_valid <= 1'b0;
      end
      if (b_drain) begin
        b_count <= b_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Scoreboard bench for stream_demux_1_2: stimulus pushes expected beats per channel,
// a negedge monitor pops and compares them whenever an output handshake is about to occur.
module tb_stream_demux_1_2;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_data;
  logic          a_valid;
  logic          a_ready;
  logic [DW-1:0] b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int passCount  = 0;
  int checkCount = 0;

  logic [DW-1:0] expA[$];
  logic [DW-1:0] expB[$];
  logic [CW-1:0] modelA = '0;
  logic [CW-1:0] modelB = '0;
  logic          checkAvalid = 1'b0;
  int            stalls;

  stream_demux_1_2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    waitCycles(2);
    rst = 1'b0;
  endtask

  // Offers one beat and holds it until accepted; the beat is queued for its channel
  // on the sampling half-cycle just before the accepting edge.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic sel, output int nStall);
    nStall   = 0;
    in_data  = data;
    in_sel   = sel;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (checkAvalid) checkOutput("a_valid_continuous", 32'(a_valid), 32'd1);
      if (in_ready) begin
        if (sel) expB.push_back(data);
        else     expA.push_back(data);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
      nStall++;
      if (nStall > 50) begin
        checkOutput("accept_timeout", 32'(nStall), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  // Monitor: a handshake visible at the negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      expA.delete();
      expB.delete();
      modelA = '0;
      modelB = '0;
    end else begin
      if (a_valid && a_ready) begin
        if (expA.size() == 0) begin
          checkOutput("a_spurious_beat", 32'(expA.size()), 32'd1);
        end else begin
          checkOutput("a_data", 32'(a_data), 32'(expA.pop_front()));
          checkOutput("a_count_running", 32'(a_count), 32'(modelA));
          modelA = modelA + 1'b1;
        end
      end
      if (b_valid && b_ready) begin
        if (expB.size() == 0) begin
          checkOutput("b_spurious_beat", 32'(expB.size()), 32'd1);
        end else begin
          checkOutput("b_data", 32'(b_data), 32'(expB.pop_front()));
          checkOutput("b_count_running", 32'(b_count), 32'(modelB));
          modelB = modelB + 1'b1;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] altData [4];
    logic          altSel  [4];
    altData = '{8'h11, 8'h22, 8'h33, 8'h44};
    altSel  = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;

    // Reset then idle
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("reset_a_valid", 32'(a_valid), 32'd0);
    checkOutput("reset_b_valid", 32'(b_valid), 32'd0);
    checkOutput("reset_a_count", 32'(a_count), 32'd0);
    checkOutput("reset_b_count", 32'(b_count), 32'd0);
    in_sel = 1'b0; #1;
    checkOutput("idle_in_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1; #1;
    checkOutput("idle_in_ready_sel1", 32'(in_ready), 32'd1);

    // Alternating stream, both consumers always ready
    $display("[TB] alternating stream");
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(altData[i], altSel[i], stalls);
      checkOutput("alt_no_stall", 32'(stalls), 32'd0);
      if (altSel[i]) checkOutput("alt_b_latency", 32'(b_data), 32'(altData[i]));
      else           checkOutput("alt_a_latency", 32'(a_data), 32'(altData[i]));
    end
    waitCycles(3);
    checkOutput("alt_a_count", 32'(a_count), 32'd2);
    checkOutput("alt_b_count", 32'(b_count), 32'd2);

    // Head-of-line isolation: A stalled, B keeps flowing
    $display("[TB] head-of-line isolation");
    doReset();
    a_ready = 1'b0; b_ready = 1'b1;
    applyStimulus(8'h5A, 1'b0, stalls);
    checkOutput("hol_5a_no_stall", 32'(stalls), 32'd0);
    applyStimulus(8'h77, 1'b1, stalls);
    checkOutput("hol_77_no_stall", 32'(stalls), 32'd0);
    waitCycles(2);
    checkOutput("hol_b_count", 32'(b_count), 32'd1);
    checkOutput("hol_a_still_full", 32'(a_valid), 32'd1);
    in_data = 8'hA5; in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hol_in_ready_low", 32'(in_ready), 32'd0);
      checkOutput("hol_a_data_stable", 32'(a_data), 32'h5A);
    end
    @(posedge clk); #1;
    a_ready = 1'b1;
    @(negedge clk);
    checkOutput("hol_in_ready_release", 32'(in_ready), 32'd1);
    expA.push_back(8'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitCycles(3);
    checkOutput("hol_a_count", 32'(a_count), 32'd2);

    // Full-throughput refill on A
    $display("[TB] full-throughput refill");
    doReset();
    a_ready = 1'b1; b_ready = 1'b1;
    applyStimulus(8'h80, 1'b0, stalls);
    checkAvalid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      applyStimulus(8'h80 + 8'(i), 1'b0, stalls);
      checkOutput("refill_no_stall", 32'(stalls), 32'd0);
    end
    @(negedge clk);
    checkOutput("refill_last_valid", 32'(a_valid), 32'd1);
    checkAvalid = 1'b0;
    waitCycles(2);
    checkOutput("refill_a_count", 32'(a_count), 32'd8);
    checkOutput("refill_a_drained", 32'(a_valid), 32'd0);

    // Counter wrap on B with a 4-bit counter
    $display("[TB] counter wrap");
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(8'(i), 1'b1, stalls);
    waitCycles(3);
    checkOutput("wrap_b_count_15", 32'(b_count), 32'd15);
    applyStimulus(8'hF0, 1'b1, stalls);
    waitCycles(3);
    checkOutput("wrap_b_count_16", 32'(b_count), 32'd0);
    applyStimulus(8'hF1, 1'b1, stalls);
    waitCycles(3);
    checkOutput("wrap_b_count_17", 32'(b_count), 32'd1);

    // Reset mid-operation with both channels full and consumers going ready
    $display("[TB] reset mid-operation");
    doReset();
    a_ready = 1'b0; b_ready = 1'b0;
    applyStimulus(8'hC3, 1'b0, stalls);
    applyStimulus(8'h3C, 1'b1, stalls);
    @(negedge clk);
    checkOutput("mid_a_full", 32'(a_data), 32'hC3);
    checkOutput("mid_b_full", 32'(b_data), 32'h3C);
    @(posedge clk); #1;
    rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_a_valid", 32'(a_valid), 32'd0);
    checkOutput("mid_b_valid", 32'(b_valid), 32'd0);
    checkOutput("mid_a_data", 32'(a_data), 32'd0);
    checkOutput("mid_b_data", 32'(b_data), 32'd0);
    checkOutput("mid_a_count", 32'(a_count), 32'd0);
    checkOutput("mid_b_count", 32'(b_count), 32'd0);

    waitCycles(3);
    checkOutput("final_expA_empty", 32'(expA.size()), 32'd0);
    checkOutput("final_expB_empty", 32'(expB.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
